cpu_ula_mc: RTL

Multi-cycle, width-parametrised ALU for the CPU datapath.
- Executes ADD, ADDI, SUB, SUBI and MUL under an explicit start/done handshake.
- Supports asynchronous reset, status flags and illegal-opcode reporting.
- MUL runs through an iterative shift-add multiplier, so the control unit must wait on `done` rather than count cycles.

---
 rtl/cpu_ula_pkg.sv | 25 ++
 rtl/cpu_ula_mc_if.sv | 27 ++
 rtl/cpu_ula_mul.sv | 58 +++++
 rtl/cpu_ula_mc.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/cpu_ula_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, FSM states, legality check.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package cpu_ula_pkg;

  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_SUBI = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_MUL    = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  // True for the five opcodes the ALU executes; everything else is reported as illegal.
  function automatic logic op_legal(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_ADDI) || (op == OP_SUB) ||
           (op == OP_SUBI) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/cpu_ula_mc_if.sv
// Request/response bundle between the control unit and the multi-cycle ALU.
// Latency: wires only.
// Backpressure: requester must wait for done; start outside IDLE is dropped by the ALU.
interface cpu_ula_mc_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [2:0]       op_code;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] op_result;
  logic             zero;
  logic             carry;
  logic             illegal;

  modport master (
    output start, op_code, src1, src2,
    input  busy, done, op_result, zero, carry, illegal
  );

  modport slave (
    input  start, op_code, src1, src2,
    output busy, done, op_result, zero, carry, illegal
  );
endinterface

// File: rtl/cpu_ula_mul.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, 2*WIDTH-bit product.
// Latency: start sampled at edge 0, product valid and done pulsed after edge WIDTH.
// Backpressure: none; a new start restarts the multiply, caller must wait for done.
module cpu_ula_mul #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               running;

  // Shift-add iteration: add the shifted multiplicand when the current multiplier bit is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc     <= '0;
        mcand   <= {{WIDTH{1'b0}}, a};
        mplier  <= b;
        cnt     <= '0;
        running <= 1'b1;
      end else if (running) begin
        if (mplier[0]) begin
          acc <= acc + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

  assign product = acc;

endmodule

// File: rtl/cpu_ula_mc.sv
// Multi-cycle ALU: ADD/ADDI/SUB/SUBI in a CALC step, MUL through the iterative multiplier.
// Latency: done after edge 2 (ALU), edge WIDTH+2 (MUL), edge 1 (illegal opcode).
// Backpressure: start accepted only in IDLE; requests while busy are dropped, not queued.
module cpu_ula_mc
  import cpu_ula_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IMM_W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  cpu_ula_mc_if.slave  bus
);

  state_t             state;
  state_t             state_nxt;
  logic               accept;
  logic               legal;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;

  logic [WIDTH-1:0]   mag;
  logic               imm_sign;
  logic               is_sub;
  logic [WIDTH-1:0]   opb;
  logic [WIDTH:0]     ext;

  logic [WIDTH-1:0]   res_q;
  logic               zero_q;
  logic               carry_q;
  logic               illegal_q;
  logic               done_q;

  assign accept = (state == S_IDLE) && bus.start;
  assign legal  = op_legal(bus.op_code);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; the multiplier is kicked off on the accepting edge with the live operands.
  always_comb begin
    state_nxt = state;
    mul_start = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (!legal) begin
            state_nxt = S_FINISH;
          end else if (bus.op_code == OP_MUL) begin
            state_nxt = S_MUL;
            mul_start = 1'b1;
          end else begin
            state_nxt = S_CALC;
          end
        end
      end
      S_CALC:   state_nxt = S_FINISH;
      S_MUL:    if (mul_done) state_nxt = S_FINISH;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Add/subtract path; the immediate is sign-magnitude, so its sign flips add vs subtract.
  always_comb begin
    mag      = {{(WIDTH-IMM_W+1){1'b0}}, b_q[IMM_W-2:0]};
    imm_sign = b_q[IMM_W-1];
    is_sub   = 1'b0;
    opb      = b_q;
    case (op_q)
      OP_SUB:  is_sub = 1'b1;
      OP_ADDI: begin
        is_sub = imm_sign;
        opb    = mag;
      end
      OP_SUBI: begin
        is_sub = !imm_sign;
        opb    = mag;
      end
      default: is_sub = 1'b0;
    endcase
    // The extra top bit is the carry-out for adds and the borrow for subtracts.
    ext = is_sub ? ({1'b0, a_q} - {1'b0, opb}) : ({1'b0, a_q} + {1'b0, opb});
  end

  cpu_ula_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (bus.src1),
    .b       (bus.src2),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Operand latch, result/flag registers and the registered done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      illegal_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= (state == S_FINISH);
      if (accept) begin
        if (legal) begin
          op_q      <= bus.op_code;
          a_q       <= bus.src1;
          b_q       <= bus.src2;
          illegal_q <= 1'b0;
        end else begin
          illegal_q <= 1'b1;
        end
      end
      if (state == S_CALC) begin
        res_q   <= ext[WIDTH-1:0];
        carry_q <= ext[WIDTH];
        zero_q  <= (ext[WIDTH-1:0] == '0);
      end else if ((state == S_MUL) && mul_done) begin
        res_q   <= mul_prod[WIDTH-1:0];
        carry_q <= |mul_prod[2*WIDTH-1:WIDTH];
        zero_q  <= (mul_prod[WIDTH-1:0] == '0);
      end
    end
  end

  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = done_q;
  assign bus.op_result = res_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
  assign bus.illegal   = illegal_q;

endmodule
